bus_master_if: RTL and testbench
================================

// Module: bus_master_if
// PURPOSE
// - Initiator-side bus interface: turns a single-word core access request into the shared-bus
//   request/grant/strobe/ready handshake and returns read data and completion to the core.
// - One instance per bus master port, 0..3. It drives req[n], m_as[n], m_rw[n], mN_addr and
//   mN_rw_data, and consumes grnt[n], m_rdy and m_rd_data.
// - At most one outstanding transaction. A watchdog aborts accesses that never get bus_rdy.
// PARAMETERS
// - WORD_W   32  data width
// - ADDR_W   30  word-address width; bits [ADDR_W-1:ADDR_W-3] select the slave
// - TIMEOUT  256 ACCESS cycles without bus_rdy before abort; 0 disables the watchdog
// PORTS
// - clk          in  1       clock
// - rst          in  1       reset, asynchronous, active-low
// - core_req     in  1       access request; sampled only in IDLE
// - core_rw      in  1       1=read, 0=write
// - core_addr    in  ADDR_W  word address
// - core_wr_data in  WORD_W  write data
// - core_busy    out 1       high while state != IDLE
// - core_done    out 1       1-cycle pulse: transaction finished
// - core_err     out 1       valid with core_done; 1 = timeout abort
// - core_rd_data out WORD_W  read data; held until next core_done
// - bus_req      out 1       to arbiter req[n]
// - bus_grnt     in  1       from arbiter grnt[n]
// - bus_as       out 1       address strobe, active-high
// - bus_rw       out 1       1=read, 0=write
// - bus_addr     out ADDR_W  to mN_addr
// - bus_wr_data  out WORD_W  to mN_rw_data
// - bus_rdy      in  1       m_rdy from slave mux, active-high
// - bus_rd_data  in  WORD_W  m_rd_data from slave mux
// BEHAVIOUR
// - Reset values: state IDLE, bus_req=0, bus_as=0, bus_rw=1, bus_addr=0, bus_wr_data=0,
//   core_busy=0, core_done=0, core_err=0, core_rd_data=0, watchdog=0. All outputs registered.
//   Reset mid-transaction abandons the access immediately (async).
// - IDLE: if core_req, capture rw/addr/wr_data into bus_* regs, bus_req<=1, go to REQ.
//   A request presented in the same cycle as core_done is accepted (done leaves state IDLE).
// - REQ: bus_req=1. If bus_grnt, go to ACCESS and set bus_as<=1. Otherwise wait, with no limit.
// - ACCESS: bus_req=1, bus_as=1 (level, held until rdy), bus_addr/rw/wr_data stable.
//   - bus_rdy=1: capture bus_rd_data on reads (core_rd_data unchanged on writes),
//     core_done<=1, core_err<=0, bus_req<=0, bus_as<=0, go to IDLE.
//   - bus_grnt drops without rdy (lost grant): bus_as<=0, watchdog cleared, go to REQ and re-issue.
//   - watchdog==TIMEOUT-1 without rdy (TIMEOUT!=0): core_done<=1, core_err<=1,
//     core_rd_data<=0, bus_req<=0, bus_as<=0, go to IDLE.
//   - rdy and timeout in the same cycle: rdy wins, no error.
// - Watchdog: counts in ACCESS only, cleared on ACCESS entry; width $clog2(TIMEOUT+1).
// - Latency: core_req at cycle 0 -> REQ at 1 -> ACCESS at 2 if granted -> core_done at 3 with a
//   zero-wait slave. Each slave wait cycle adds 1.
// - core_req while busy is ignored; the core holds it until core_busy falls.
// - The arbiter keeps its owner while more than one req is high, so holding bus_req through
//   ACCESS keeps the grant.
// STRUCTURE
// - Shared package: WORD_W/ADDR_W defaults; RW_READ=1, RW_WRITE=0; state encoding
//   IDLE=2'd0, REQ=2'd1, ACCESS=2'd2.
// - Single flat module; the watchdog stays inline (one counter), no sub-module.
// TESTING
// - Zero-wait read, grant already held: core_req rw=1 addr=0x1000_0004, rdy in first ACCESS
//   cycle with data 0xDEADBEEF -> core_done at cycle 3, rd_data=0xDEADBEEF, err=0.
// - Write, 2 wait states: addr=0x0800_0010, wr_data=0x1234_5678 -> bus_as high 3 cycles with
//   stable addr/data, done at cycle 5, rd_data unchanged.
// - Contention: grant held by master 1 for 4 cycles -> bus_as stays 0 in REQ, ACCESS starts the
//   cycle after grnt rises, bus_req never drops.
// - Timeout with TIMEOUT=8, no rdy -> bus_as high exactly 8 cycles, done=1, err=1, rd_data=0.
// - Back-to-back: core_req held high across core_done -> second access enters REQ the cycle
//   after done. Lost grant in ACCESS -> returns to REQ and re-strobes.
// - rst low in ACCESS -> all outputs reach reset values immediately. After release, a fresh
//   read completes normally.

Source files
------------

// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the bus master interface slice.
// Contents:
//   WORD_W_DEF / ADDR_W_DEF : default data and word-address widths
//   RW_READ / RW_WRITE      : encoding of the rw direction bit
//   state_e                 : transaction FSM state encoding
package bus_master_if_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int ADDR_W_DEF = 30;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/bus_master_if_if.sv
// Shared-bus signal bundle between one bus master port and the arbiter/slave mux.
// Signals:
//   bus_req      master -> arbiter   request (req[n])
//   bus_grnt     arbiter -> master   grant (grnt[n])
//   bus_as       master -> bus       address strobe, active-high
//   bus_rw       master -> bus       1=read, 0=write
//   bus_addr     master -> bus       word address (mN_addr)
//   bus_wr_data  master -> bus       write data (mN_rw_data)
//   bus_rdy      slave mux -> master access complete (m_rdy)
//   bus_rd_data  slave mux -> master read data (m_rd_data)
// Modports: master (initiator side), slave (arbiter/slave-mux side).
interface bus_master_if_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) ();

  logic              bus_req;
  logic              bus_grnt;
  logic              bus_as;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [WORD_W-1:0] bus_wr_data;
  logic              bus_rdy;
  logic [WORD_W-1:0] bus_rd_data;

  modport master (
    output bus_req,
    output bus_as,
    output bus_rw,
    output bus_addr,
    output bus_wr_data,
    input  bus_grnt,
    input  bus_rdy,
    input  bus_rd_data
  );

  modport slave (
    input  bus_req,
    input  bus_as,
    input  bus_rw,
    input  bus_addr,
    input  bus_wr_data,
    output bus_grnt,
    output bus_rdy,
    output bus_rd_data
  );

endinterface

// File: rtl/bus_master_if.sv
// Initiator-side bus interface: converts a single-word core access into the shared-bus
// request/grant/strobe/ready handshake and returns read data plus completion to the core.
// At most one transaction is outstanding; a watchdog aborts accesses that never see rdy.
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   core_req      access request, sampled only in IDLE
//   core_rw       1=read, 0=write
//   core_addr     word address
//   core_wr_data  write data
//   core_busy     high while a transaction is in flight
//   core_done     one-cycle completion pulse
//   core_err      valid with core_done; 1 = watchdog abort
//   core_rd_data  read data, held until the next core_done
//   bus           bus_master_if_if.master bundle (req/grnt/as/rw/addr/wr_data/rdy/rd_data)
// Parameters: WORD_W, ADDR_W, TIMEOUT (ACCESS cycles before abort, 0 disables).
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [WORD_W-1:0] core_wr_data,
  output logic              core_busy,
  output logic              core_done,
  output logic              core_err,
  output logic [WORD_W-1:0] core_rd_data,
  bus_master_if_if.master   bus
);

  // A zero TIMEOUT still needs a legal one-bit counter even though it never fires.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [WD_W-1:0] WD_ZERO = WD_W'(1'b0);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1'b1);

  state_e            state_r,        state_nxt_s;
  logic              bus_req_r,      bus_req_nxt_s;
  logic              bus_as_r,       bus_as_nxt_s;
  logic              bus_rw_r,       bus_rw_nxt_s;
  logic [ADDR_W-1:0] bus_addr_r,     bus_addr_nxt_s;
  logic [WORD_W-1:0] bus_wr_data_r,  bus_wr_data_nxt_s;
  logic              core_busy_r,    core_busy_nxt_s;
  logic              core_done_r,    core_done_nxt_s;
  logic              core_err_r,     core_err_nxt_s;
  logic [WORD_W-1:0] core_rd_data_r, core_rd_data_nxt_s;
  logic [WD_W-1:0]   wd_r,           wd_nxt_s;
  logic              timeout_s;

  assign timeout_s = (TIMEOUT != 0) && (wd_r == WD_LAST);

  // Next-state and next-output decode for the transaction FSM.
  always_comb begin
    state_nxt_s        = state_r;
    bus_req_nxt_s      = bus_req_r;
    bus_as_nxt_s       = bus_as_r;
    bus_rw_nxt_s       = bus_rw_r;
    bus_addr_nxt_s     = bus_addr_r;
    bus_wr_data_nxt_s  = bus_wr_data_r;
    core_done_nxt_s    = 1'b0;
    core_err_nxt_s     = core_err_r;
    core_rd_data_nxt_s = core_rd_data_r;
    wd_nxt_s           = wd_r;

    case (state_r)
      IDLE: begin
        // core_done is registered, so a request seen in the done cycle is taken here.
        if (core_req) begin
          bus_rw_nxt_s      = core_rw;
          bus_addr_nxt_s    = core_addr;
          bus_wr_data_nxt_s = core_wr_data;
          bus_req_nxt_s     = 1'b1;
          state_nxt_s       = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      REQ: begin
        // No limit on arbitration wait; the watchdog only guards the slave.
        if (bus.bus_grnt) begin
          bus_as_nxt_s = 1'b1;
          wd_nxt_s     = WD_ZERO;
          state_nxt_s  = ACCESS;
        end else begin
          state_nxt_s = REQ;
        end
      end

      ACCESS: begin
        // rdy has priority over both lost grant and timeout.
        if (bus.bus_rdy) begin
          if (bus_rw_r == RW_READ) begin
            core_rd_data_nxt_s = bus.bus_rd_data;
          end else begin
            core_rd_data_nxt_s = core_rd_data_r;
          end
          core_done_nxt_s = 1'b1;
          core_err_nxt_s  = 1'b0;
          bus_req_nxt_s   = 1'b0;
          bus_as_nxt_s    = 1'b0;
          wd_nxt_s        = WD_ZERO;
          state_nxt_s     = IDLE;
        end else if (!bus.bus_grnt) begin
          // Grant taken away mid-access: drop strobe and re-arbitrate with req still high.
          bus_as_nxt_s = 1'b0;
          wd_nxt_s     = WD_ZERO;
          state_nxt_s  = REQ;
        end else if (timeout_s) begin
          core_done_nxt_s    = 1'b1;
          core_err_nxt_s     = 1'b1;
          core_rd_data_nxt_s = {WORD_W{1'b0}};
          bus_req_nxt_s      = 1'b0;
          bus_as_nxt_s       = 1'b0;
          wd_nxt_s           = WD_ZERO;
          state_nxt_s        = IDLE;
        end else begin
          wd_nxt_s    = wd_r + WD_ONE;
          state_nxt_s = ACCESS;
        end
      end

      default: begin
        bus_req_nxt_s = 1'b0;
        bus_as_nxt_s  = 1'b0;
        wd_nxt_s      = WD_ZERO;
        state_nxt_s   = IDLE;
      end
    endcase

    core_busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      bus_req_r      <= 1'b0;
      bus_as_r       <= 1'b0;
      bus_rw_r       <= RW_READ;
      bus_addr_r     <= {ADDR_W{1'b0}};
      bus_wr_data_r  <= {WORD_W{1'b0}};
      core_busy_r    <= 1'b0;
      core_done_r    <= 1'b0;
      core_err_r     <= 1'b0;
      core_rd_data_r <= {WORD_W{1'b0}};
      wd_r           <= WD_ZERO;
    end else begin
      state_r        <= state_nxt_s;
      bus_req_r      <= bus_req_nxt_s;
      bus_as_r       <= bus_as_nxt_s;
      bus_rw_r       <= bus_rw_nxt_s;
      bus_addr_r     <= bus_addr_nxt_s;
      bus_wr_data_r  <= bus_wr_data_nxt_s;
      core_busy_r    <= core_busy_nxt_s;
      core_done_r    <= core_done_nxt_s;
      core_err_r     <= core_err_nxt_s;
      core_rd_data_r <= core_rd_data_nxt_s;
      wd_r           <= wd_nxt_s;
    end
  end

  assign core_busy       = core_busy_r;
  assign core_done       = core_done_r;
  assign core_err        = core_err_r;
  assign core_rd_data    = core_rd_data_r;
  assign bus.bus_req     = bus_req_r;
  assign bus.bus_as      = bus_as_r;
  assign bus.bus_rw      = bus_rw_r;
  assign bus.bus_addr    = bus_addr_r;
  assign bus.bus_wr_data = bus_wr_data_r;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed self-checking bench for bus_master_if (TIMEOUT=8).
// Drives the core side and plays arbiter/slave through the interface instance.
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  localparam int AW = 30;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_req = 1'b0;
  logic          core_rw = 1'b1;
  logic [AW-1:0] core_addr = '0;
  logic [WW-1:0] core_wr_data = '0;
  logic          core_busy;
  logic          core_done;
  logic          core_err;
  logic [WW-1:0] core_rd_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_master_if_if #(.ADDR_W(AW), .WORD_W(WW)) bus_i ();

  bus_master_if #(.WORD_W(WW), .ADDR_W(AW), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_req     (core_req),
    .core_rw      (core_rw),
    .core_addr    (core_addr),
    .core_wr_data (core_wr_data),
    .core_busy    (core_busy),
    .core_done    (core_done),
    .core_err     (core_err),
    .core_rd_data (core_rd_data),
    .bus          (bus_i)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_vec({pfx, "_req"},   32'(bus_i.bus_req),     32'd0);
    check_vec({pfx, "_as"},    32'(bus_i.bus_as),      32'd0);
    check_vec({pfx, "_rw"},    32'(bus_i.bus_rw),      32'd1);
    check_vec({pfx, "_addr"},  32'(bus_i.bus_addr),    32'd0);
    check_vec({pfx, "_wdat"},  bus_i.bus_wr_data,      32'd0);
    check_vec({pfx, "_busy"},  32'(core_busy),         32'd0);
    check_vec({pfx, "_done"},  32'(core_done),         32'd0);
    check_vec({pfx, "_err"},   32'(core_err),          32'd0);
    check_vec({pfx, "_rdat"},  core_rd_data,           32'd0);
  endtask

  task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [WW-1:0] wd);
    core_req     = 1'b1;
    core_rw      = rw;
    core_addr    = addr;
    core_wr_data = wd;
  endtask

  initial begin
    int as_cnt;
    bit done_seen;

    bus_i.bus_grnt    = 1'b0;
    bus_i.bus_rdy     = 1'b0;
    bus_i.bus_rd_data = '0;

    // ---------------- reset ----------------
    tick(); tick();
    check_reset_vals("rst");
    rst = 1'b1;

    // ---------------- zero-wait read, grant held ----------------
    bus_i.bus_grnt = 1'b1;
    issue(RW_READ, 30'h1000_0004, 32'h0000_0000);
    tick();                                  // cycle 1: REQ
    core_req = 1'b0;
    check_vec("rd_c1_req",  32'(bus_i.bus_req),  32'd1);
    check_vec("rd_c1_as",   32'(bus_i.bus_as),   32'd0);
    check_vec("rd_c1_busy", 32'(core_busy),      32'd1);
    check_vec("rd_c1_addr", 32'(bus_i.bus_addr), 32'h1000_0004);
    tick();                                  // cycle 2: ACCESS
    check_vec("rd_c2_as",   32'(bus_i.bus_as),   32'd1);
    check_vec("rd_c2_rw",   32'(bus_i.bus_rw),   32'd1);
    bus_i.bus_rdy     = 1'b1;
    bus_i.bus_rd_data = 32'hDEAD_BEEF;
    tick();                                  // cycle 3: done
    bus_i.bus_rdy     = 1'b0;
    bus_i.bus_rd_data = 32'h0000_0000;
    check_vec("rd_c3_done", 32'(core_done),      32'd1);
    check_vec("rd_c3_err",  32'(core_err),       32'd0);
    check_vec("rd_c3_data", core_rd_data,        32'hDEAD_BEEF);
    check_vec("rd_c3_as",   32'(bus_i.bus_as),   32'd0);
    check_vec("rd_c3_req",  32'(bus_i.bus_req),  32'd0);
    check_vec("rd_c3_busy", 32'(core_busy),      32'd0);
    tick();
    check_vec("rd_c4_done", 32'(core_done),      32'd0);

    // ---------------- write, 2 wait states ----------------
    issue(RW_WRITE, 30'h0800_0010, 32'h1234_5678);
    tick();                                  // cycle 1: REQ
    core_req = 1'b0;
    as_cnt = 0;
    for (int c = 2; c <= 4; c++) begin
      tick();                                // cycles 2..4: ACCESS
      if (bus_i.bus_as) as_cnt++;
      check_vec("wr_addr", 32'(bus_i.bus_addr), 32'h0800_0010);
      check_vec("wr_data", bus_i.bus_wr_data,   32'h1234_5678);
      check_vec("wr_rw",   32'(bus_i.bus_rw),   32'd0);
      check_vec("wr_done_early", 32'(core_done), 32'd0);
      if (c == 4) bus_i.bus_rdy = 1'b1;
    end
    tick();                                  // cycle 5: done
    bus_i.bus_rdy = 1'b0;
    check_vec("wr_as_cycles", 32'(as_cnt),     32'd3);
    check_vec("wr_c5_done",   32'(core_done),  32'd1);
    check_vec("wr_c5_err",    32'(core_err),   32'd0);
    check_vec("wr_c5_rdat",   core_rd_data,    32'hDEAD_BEEF);
    tick();

    // ---------------- contention: grant elsewhere for 4 cycles ----------------
    bus_i.bus_grnt = 1'b0;
    issue(RW_READ, 30'h2000_0100, 32'h0000_0000);
    for (int c = 1; c <= 4; c++) begin
      tick();                                // REQ, waiting for grant
      core_req = 1'b0;
      check_vec("ct_wait_as",  32'(bus_i.bus_as),  32'd0);
      check_vec("ct_wait_req", 32'(bus_i.bus_req), 32'd1);
    end
    bus_i.bus_grnt = 1'b1;
    tick();                                  // ACCESS the cycle after grant
    check_vec("ct_as",  32'(bus_i.bus_as),  32'd1);
    check_vec("ct_req", 32'(bus_i.bus_req), 32'd1);
    bus_i.bus_rdy     = 1'b1;
    bus_i.bus_rd_data = 32'hA5A5_0001;
    tick();
    bus_i.bus_rdy = 1'b0;
    check_vec("ct_done", 32'(core_done), 32'd1);
    check_vec("ct_rdat", core_rd_data,   32'hA5A5_0001);
    tick();

    // ---------------- timeout: no rdy ----------------
    issue(RW_READ, 30'h3000_0000, 32'h0000_0000);
    tick();
    core_req  = 1'b0;
    as_cnt    = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      tick();
      if (bus_i.bus_as) as_cnt++;
      if (core_done) done_seen = 1'b1;
    end
    check_vec("to_done_seen", 32'(done_seen),  32'd1);
    check_vec("to_as_cycles", 32'(as_cnt),     32'd8);
    check_vec("to_err",       32'(core_err),   32'd1);
    check_vec("to_rdat",      core_rd_data,    32'd0);
    check_vec("to_req",       32'(bus_i.bus_req), 32'd0);
    tick();

    // ---------------- rdy on the last watchdog cycle wins ----------------
    issue(RW_READ, 30'h3000_0008, 32'h0000_0000);
    tick();                                  // REQ
    core_req = 1'b0;
    tick();                                  // first ACCESS cycle
    check_vec("tb_as_first", 32'(bus_i.bus_as), 32'd1);
    repeat (7) tick();                       // eighth ACCESS cycle
    check_vec("tb_as_last",  32'(bus_i.bus_as), 32'd1);
    check_vec("tb_nodone",   32'(core_done),    32'd0);
    bus_i.bus_rdy     = 1'b1;
    bus_i.bus_rd_data = 32'h7777_0008;
    tick();
    bus_i.bus_rdy = 1'b0;
    check_vec("tb_done", 32'(core_done), 32'd1);
    check_vec("tb_err",  32'(core_err),  32'd0);
    check_vec("tb_rdat", core_rd_data,   32'h7777_0008);
    tick();

    // ---------------- back-to-back + lost grant ----------------
    issue(RW_WRITE, 30'h0400_0020, 32'hCAFE_0001);
    tick();                                  // REQ
    tick();                                  // ACCESS
    bus_i.bus_rdy = 1'b1;
    tick();                                  // done; core_req still high
    bus_i.bus_rdy = 1'b0;
    check_vec("bb_done1", 32'(core_done), 32'd1);
    check_vec("bb_busy1", 32'(core_busy), 32'd0);
    issue(RW_READ, 30'h0C00_0040, 32'h0000_0000);
    tick();                                  // second access in REQ
    core_req = 1'b0;
    check_vec("bb_req2",  32'(bus_i.bus_req),  32'd1);
    check_vec("bb_busy2", 32'(core_busy),      32'd1);
    check_vec("bb_addr2", 32'(bus_i.bus_addr), 32'h0C00_0040);
    check_vec("bb_done2", 32'(core_done),      32'd0);
    tick();                                  // ACCESS
    check_vec("lg_as1", 32'(bus_i.bus_as), 32'd1);
    bus_i.bus_grnt = 1'b0;
    tick();                                  // back to REQ
    check_vec("lg_as_drop", 32'(bus_i.bus_as),  32'd0);
    check_vec("lg_req",     32'(bus_i.bus_req), 32'd1);
    check_vec("lg_done",    32'(core_done),     32'd0);
    bus_i.bus_grnt = 1'b1;
    tick();                                  // re-strobe
    check_vec("lg_as2",   32'(bus_i.bus_as),   32'd1);
    check_vec("lg_addr2", 32'(bus_i.bus_addr), 32'h0C00_0040);
    bus_i.bus_rdy     = 1'b1;
    bus_i.bus_rd_data = 32'h0BAD_F00D;
    tick();
    bus_i.bus_rdy = 1'b0;
    check_vec("lg_done2", 32'(core_done), 32'd1);
    check_vec("lg_rdat",  core_rd_data,   32'h0BAD_F00D);
    tick();

    // ---------------- async reset in ACCESS ----------------
    issue(RW_READ, 30'h1000_0100, 32'h0000_0000);
    tick();
    core_req = 1'b0;
    tick();
    check_vec("ar_as_before", 32'(bus_i.bus_as), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_vals("ar");
    tick(); tick();
    rst = 1'b1;
    issue(RW_READ, 30'h1000_0200, 32'h0000_0000);
    tick();
    core_req = 1'b0;
    tick();
    check_vec("ar_fresh_as", 32'(bus_i.bus_as), 32'd1);
    bus_i.bus_rdy     = 1'b1;
    bus_i.bus_rd_data = 32'h5555_AAAA;
    tick();
    bus_i.bus_rdy = 1'b0;
    check_vec("ar_fresh_done", 32'(core_done), 32'd1);
    check_vec("ar_fresh_err",  32'(core_err),  32'd0);
    check_vec("ar_fresh_rdat", core_rd_data,   32'h5555_AAAA);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
